// File: rtl/siso_rr_shift_ctrl.sv
// ============================================================================
// siso_rr_shift_ctrl : round-robin arbiter feeding one MSB-first serial shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

module siso_rr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  output logic             sout_o,
  output logic             sframe_o,
  output logic             sowner_o,
  output logic             done_o
);

  localparam int CW  = $clog2(WIDTH);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic [CW-1:0]    cnt_q;
  logic [GCW-1:0]   gcnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             sout_q;
  logic             sframe_q;
  logic             sowner_q;
  logic             done_q;

  logic             grant_d;
  logic             accept_d;
  logic [WIDTH-1:0] data_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_d  = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
    data_d   = grant_d ? req1_data_i : req0_data_i;
    accept_d = (state_q == ST_IDLE) && (grant_d ? req1_valid_i : req0_valid_i);
  end

  assign req0_ready_o = (state_q == ST_IDLE) && !grant_d && req0_valid_i;
  assign req1_ready_o = (state_q == ST_IDLE) &&  grant_d && req1_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sframe_q     <= 1'b0;
      sowner_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            // MSB goes straight to sout; shreg keeps the remaining bits pre-shifted.
            sout_q       <= data_d[WIDTH-1];
            shreg_q      <= {data_d[WIDTH-2:0], 1'b0};
            sframe_q     <= 1'b1;
            last_grant_q <= grant_d;
            sowner_q     <= grant_d;
            cnt_q        <= CW'(WIDTH - 1);
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            sout_q   <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b1;
            if (GAP == 0) begin
              state_q <= ST_IDLE;
            end else begin
              gcnt_q  <= GCW'(GAP - 1);
              state_q <= ST_GAP;
            end
          end else begin
            sout_q  <= shreg_q[WIDTH-1];
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sout_o   = sout_q;
  assign sframe_o = sframe_q;
  assign sowner_o = sowner_q;
  assign done_o   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_siso_rr_shift_ctrl.sv
// ============================================================================
// tb_siso_rr_shift_ctrl : directed bench for the round-robin serial shift controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_siso_rr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic       rdy0, rdy1, sout, sframe, sowner, done;
  logic       bv0 = 1'b0, bv1 = 1'b0;
  logic [3:0] bd0 = '0, bd1 = '0;
  logic       brdy0, brdy1, bsout, bsframe, bsowner, bdone;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  siso_rr_shift_ctrl #(.WIDTH(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(rdy0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(rdy1),
    .sout_o(sout), .sframe_o(sframe), .sowner_o(sowner), .done_o(done)
  );

  siso_rr_shift_ctrl #(.WIDTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid_i(bv0), .req0_data_i(bd0), .req0_ready_o(brdy0),
    .req1_valid_i(bv1), .req1_data_i(bd1), .req1_ready_o(brdy1),
    .sout_o(bsout), .sframe_o(bsframe), .sowner_o(bsowner), .done_o(bdone)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    v0 = 0; v1 = 0; bv0 = 0; bv1 = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({sout, sframe, sowner, done, rdy0, rdy1} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {sout, sframe, sowner, done, rdy0, rdy1});
    end
  endtask

  task automatic test_single_frame;
    logic [3:0] d;
    d = 4'b1011;
    do_reset();
    v0 = 1; d0 = d; #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      failures++; $display("FAIL t1_ready got=%b%b exp=10", rdy0, rdy1);
    end
    tick();
    v0 = 0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (sframe !== 1'b1 || sout !== d[3-b] || sowner !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL t1_bit%0d got fr=%b so=%b own=%b dn=%b exp fr=1 so=%b own=0 dn=0",
                 b, sframe, sout, sowner, done, d[3-b]);
      end
      tick();
    end
    v0 = 1; #1;
    checks++;
    if (done !== 1'b1 || sframe !== 1'b0 || sout !== 1'b0 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL t1_done_gap got dn=%b fr=%b so=%b rdy0=%b exp 1 0 0 0", done, sframe, sout, rdy0);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rdy0 !== 1'b1) begin
      failures++; $display("FAIL t1_idle got dn=%b rdy0=%b exp 0 1", done, rdy0);
    end
    v0 = 0;
  endtask

  task automatic test_round_robin;
    logic [3:0] d;
    logic       own;
    do_reset();
    v0 = 1; v1 = 1; d0 = 4'hA; d1 = 4'h5; #1;
    for (int f = 0; f < 3; f++) begin
      own = f[0];
      d   = own ? 4'h5 : 4'hA;
      checks++;
      if (rdy0 !== ~own || rdy1 !== own) begin
        failures++; $display("FAIL t2_grant f%0d got=%b%b exp=%b%b", f, rdy0, rdy1, ~own, own);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (sframe !== 1'b1 || sout !== d[3-b] || sowner !== own) begin
          failures++;
          $display("FAIL t2_f%0d_bit%0d got fr=%b so=%b own=%b exp fr=1 so=%b own=%b",
                   f, b, sframe, sout, sowner, d[3-b], own);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        failures++; $display("FAIL t2_gap f%0d got dn=%b rdy=%b%b exp 1 00", f, done, rdy0, rdy1);
      end
      tick();
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_single_requester;
    do_reset();
    v1 = 1; d1 = 4'hF; #1;
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
        failures++; $display("FAIL t3_ready f%0d got=%b%b exp=01", f, rdy0, rdy1);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (sframe !== 1'b1 || sout !== 1'b1 || sowner !== 1'b1) begin
          failures++;
          $display("FAIL t3_f%0d_bit%0d got fr=%b so=%b own=%b exp 1 1 1", f, b, sframe, sout, sowner);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        failures++; $display("FAIL t3_gap f%0d got dn=%b rdy=%b%b exp 1 00", f, done, rdy0, rdy1);
      end
      tick();
    end
    v1 = 0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] d;
    d = 4'h9;
    do_reset();
    bv0 = 1; bd0 = d; #1;
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (brdy0 !== 1'b1 || bsframe !== 1'b0 || bdone !== (f == 1)) begin
        failures++;
        $display("FAIL t4_accept f%0d got rdy=%b fr=%b dn=%b exp 1 0 %b", f, brdy0, bsframe, bdone, (f == 1));
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (bsframe !== 1'b1 || bsout !== d[3-b] || bdone !== 1'b0) begin
          failures++;
          $display("FAIL t4_f%0d_bit%0d got fr=%b so=%b dn=%b exp 1 %b 0", f, b, bsframe, bsout, bdone, d[3-b]);
        end
        tick();
      end
    end
    bv0 = 0; #1;
    checks++;
    if (bdone !== 1'b1 || bsframe !== 1'b0 || brdy0 !== 1'b0) begin
      failures++; $display("FAIL t4_last_done got dn=%b fr=%b rdy=%b exp 1 0 0", bdone, bsframe, brdy0);
    end
    tick();
    checks++;
    if (bdone !== 1'b0 || bsframe !== 1'b0) begin
      failures++; $display("FAIL t4_quiet got dn=%b fr=%b exp 0 0", bdone, bsframe);
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    v0 = 1; d0 = 4'hC; #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      failures++; $display("FAIL t5_ready got=%b exp=1", rdy0);
    end
    tick();
    v0 = 0;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (sframe !== 1'b1 || sout !== 1'b1) begin
        failures++; $display("FAIL t5_bit%0d got fr=%b so=%b exp 1 1", b, sframe, sout);
      end
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (sframe !== 1'b0 || sout !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL t5_abort got fr=%b so=%b dn=%b exp 0 0 0", sframe, sout, done);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || sframe !== 1'b0) begin
        failures++; $display("FAIL t5_no_done c%0d got dn=%b fr=%b exp 0 0", c, done, sframe);
      end
    end
    v0 = 1; v1 = 1; d0 = 4'hC; d1 = 4'h3; #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      failures++; $display("FAIL t5_tie got=%b%b exp=10", rdy0, rdy1);
    end
    tick();
    v0 = 0; v1 = 0;
    checks++;
    if (sowner !== 1'b0 || sframe !== 1'b1 || sout !== 1'b1) begin
      failures++; $display("FAIL t5_reaccept got own=%b fr=%b so=%b exp 0 1 1", sowner, sframe, sout);
    end
  endtask

  task automatic test_valid_pulse;
    logic [3:0] d;
    d = 4'b1011;
    do_reset();
    v0 = 1; d0 = d; #1;
    tick();
    v0 = 0;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        v0 = 1; d0 = 4'h0; #1;
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
          failures++; $display("FAIL t6_pulse_ready got=%b%b exp=00", rdy0, rdy1);
        end
      end
      checks++;
      if (sframe !== 1'b1 || sout !== d[3-b] || sowner !== 1'b0) begin
        failures++;
        $display("FAIL t6_bit%0d got fr=%b so=%b own=%b exp 1 %b 0", b, sframe, sout, sowner, d[3-b]);
      end
      tick();
      v0 = 0;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL t6_done got=%b exp=1", done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (sframe !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL t6_no_capture c%0d got fr=%b dn=%b exp 0 0", c, sframe, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_single_requester();
    test_back_to_back();
    test_reset_mid_frame();
    test_valid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
